// File: rtl/usb_xact_engine.sv
// Host-side USB transaction engine: runs one IN or OUT transaction per request
// (token, data, handshake) with DATA0/1 toggle tracking, STALL detection and full retry.
module usb_xact_engine #(
    parameter int DATA_W      = 64,
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_LEN = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              xact_start,
    input  logic              xact_dir,
    input  logic [18:0]       token_in,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              toggle_clr,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic              stalled,
    output logic [CNT_W-1:0]  attempts,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [7:0]        enc_pid,
    output logic [18:0]       enc_token,
    output logic [DATA_W-1:0] enc_payload,
    input  logic              dec_valid,
    input  logic              dec_corrupt,
    input  logic [7:0]        dec_pid,
    input  logic [DATA_W-1:0] dec_payload
);

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TOKEN     = 3'd1;
    localparam logic [2:0] S_DATA_TX   = 3'd2;
    localparam logic [2:0] S_WAIT_HS   = 3'd3;
    localparam logic [2:0] S_WAIT_DATA = 3'd4;
    localparam logic [2:0] S_HS_TX     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [CNT_W-1:0] MAX_ATT  = CNT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_LEN - 1);

    logic [2:0]        state_reg, state_next;
    logic              dir_reg, dir_next;
    logic [18:0]       token_reg, token_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              out_tog_reg, out_tog_next;
    logic              in_tog_reg, in_tog_next;
    logic [CNT_W-1:0]  attempts_reg, attempts_next;
    logic [CNT_W-1:0]  tmo_reg, tmo_next;
    logic              success_reg, success_next;
    logic              stalled_reg, stalled_next;
    logic              dup_reg, dup_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              rd_valid_reg, rd_valid_next;

    logic enc_hs;
    logic attempt_fail;
    logic finish;
    logic fin_success;
    logic fin_stalled;

    assign enc_hs = enc_valid && enc_ready;

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        token_next    = token_reg;
        data_next     = data_reg;
        out_tog_next  = out_tog_reg;
        in_tog_next   = in_tog_reg;
        attempts_next = attempts_reg;
        tmo_next      = tmo_reg;
        success_next  = success_reg;
        stalled_next  = stalled_reg;
        dup_next      = dup_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        attempt_fail  = 1'b0;
        finish        = 1'b0;
        fin_success   = 1'b0;
        fin_stalled   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (toggle_clr) begin
                    out_tog_next = 1'b0;
                    in_tog_next  = 1'b0;
                end
                if (xact_start) begin
                    dir_next      = xact_dir;
                    token_next    = token_in;
                    data_next     = wr_data;
                    attempts_next = '0;
                    state_next    = S_TOKEN;
                end
            end
            S_TOKEN: begin
                if (enc_hs) begin
                    attempts_next = attempts_reg + 1'b1;
                    tmo_next      = '0;
                    state_next    = dir_reg ? S_WAIT_DATA : S_DATA_TX;
                end
            end
            S_DATA_TX: begin
                if (enc_hs) begin
                    tmo_next   = '0;
                    state_next = S_WAIT_HS;
                end
            end
            S_WAIT_HS: begin
                // A response in the same cycle as the timeout takes priority.
                if (dec_valid) begin
                    if (!dec_corrupt && dec_pid == PID_ACK) begin
                        out_tog_next = ~out_tog_reg;
                        finish       = 1'b1;
                        fin_success  = 1'b1;
                    end else if (!dec_corrupt && dec_pid == PID_STALL) begin
                        finish      = 1'b1;
                        fin_stalled = 1'b1;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            S_WAIT_DATA: begin
                // Corrupt packets fall through so the timeout keeps running.
                if (dec_valid && !dec_corrupt) begin
                    if (dec_pid == PID_DATA0 || dec_pid == PID_DATA1) begin
                        state_next = S_HS_TX;
                        if ((dec_pid == PID_DATA1) == in_tog_reg) begin
                            rd_data_next  = dec_payload;
                            rd_valid_next = 1'b1;
                            in_tog_next   = ~in_tog_reg;
                            dup_next      = 1'b0;
                        end else begin
                            dup_next = 1'b1;
                        end
                    end else if (dec_pid == PID_STALL) begin
                        finish      = 1'b1;
                        fin_stalled = 1'b1;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            S_HS_TX: begin
                if (enc_hs) begin
                    if (dup_reg) begin
                        attempt_fail = 1'b1;
                    end else begin
                        finish      = 1'b1;
                        fin_success = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (attempt_fail) begin
            if (attempts_reg < MAX_ATT) begin
                state_next = S_TOKEN;
            end else begin
                finish = 1'b1;
            end
        end
        if (finish) begin
            state_next   = S_DONE;
            success_next = fin_success;
            stalled_next = fin_stalled;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= S_IDLE;
            dir_reg      <= 1'b0;
            token_reg    <= '0;
            data_reg     <= '0;
            out_tog_reg  <= 1'b0;
            in_tog_reg   <= 1'b0;
            attempts_reg <= '0;
            tmo_reg      <= '0;
            success_reg  <= 1'b0;
            stalled_reg  <= 1'b0;
            dup_reg      <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            token_reg    <= token_next;
            data_reg     <= data_next;
            out_tog_reg  <= out_tog_next;
            in_tog_reg   <= in_tog_next;
            attempts_reg <= attempts_next;
            tmo_reg      <= tmo_next;
            success_reg  <= success_next;
            stalled_reg  <= stalled_next;
            dup_reg      <= dup_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign success  = done && success_reg;
    assign stalled  = done && stalled_reg;
    assign attempts = attempts_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

    // Encoder fields depend only on registered state, so they hold while stalled by enc_ready.
    assign enc_valid   = (state_reg == S_TOKEN) || (state_reg == S_DATA_TX) || (state_reg == S_HS_TX);
    assign enc_token   = (state_reg == S_TOKEN) ? token_reg : '0;
    assign enc_payload = (state_reg == S_DATA_TX) ? data_reg : '0;

    always_comb begin
        enc_pid = 8'h00;
        case (state_reg)
            S_TOKEN:   enc_pid = dir_reg ? PID_IN : PID_OUT;
            S_DATA_TX: enc_pid = out_tog_reg ? PID_DATA1 : PID_DATA0;
            S_HS_TX:   enc_pid = PID_ACK;
            default:   enc_pid = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_usb_xact_engine.sv
// Bench for usb_xact_engine: table of transactions with a reactive device model and
// scoreboards for encoder PIDs, completion results and IN data, plus hand-written corner cases.
module tb_usb_xact_engine;

    localparam int DW = 64;
    localparam int MR = 3;
    localparam int TL = 20;
    localparam int CW = 8;

    localparam logic [7:0] P_OUT = 8'hE1, P_IN = 8'h69, P_D0 = 8'hC3, P_D1 = 8'h4B;
    localparam logic [7:0] P_ACK = 8'hD2, P_NAK = 8'h5A, P_STALL = 8'h1E;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          xact_start, xact_dir, toggle_clr;
    logic [18:0]   token_in;
    logic [DW-1:0] wr_data;
    logic          busy, done, success, stalled;
    logic [CW-1:0] attempts;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          enc_valid, enc_ready;
    logic [7:0]    enc_pid;
    logic [18:0]   enc_token;
    logic [DW-1:0] enc_payload;
    logic          dec_valid, dec_corrupt;
    logic [7:0]    dec_pid;
    logic [DW-1:0] dec_payload;

    usb_xact_engine #(.DATA_W(DW), .MAX_RETRY(MR), .TIMEOUT_LEN(TL), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b), .xact_start(xact_start), .xact_dir(xact_dir),
        .token_in(token_in), .wr_data(wr_data), .toggle_clr(toggle_clr),
        .busy(busy), .done(done), .success(success), .stalled(stalled),
        .attempts(attempts), .rd_data(rd_data), .rd_valid(rd_valid),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_pid(enc_pid),
        .enc_token(enc_token), .enc_payload(enc_payload),
        .dec_valid(dec_valid), .dec_corrupt(dec_corrupt), .dec_pid(dec_pid),
        .dec_payload(dec_payload)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       none;
        logic       corrupt;
        logic [7:0] pid;
        logic [7:0] dly;
    } resp_t;

    typedef struct packed {
        logic       succ;
        logic       stl;
        logic [7:0] att;
    } done_t;

    typedef struct {
        logic        dir;
        logic        clr;
        logic [63:0] wdata;
        logic [63:0] pay;
        resp_t       r0, r1, r2;
        logic        esucc;
        logic        estl;
        int          eatt;
        logic        chk_gap;
    } vec_t;

    resp_t       resp_q[$];
    logic [7:0]  pid_q[$];
    done_t       done_q[$];
    logic [63:0] rd_q[$];
    int          tok_cyc[$];

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          inj_cnt = 0;
    logic [63:0] cur_wdata = '0;
    logic [63:0] cur_pay = '0;
    logic [18:0] cur_token = '0;
    logic        mdl_out = 1'b0;
    logic        mdl_in = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic resp_t rs(input logic [7:0] p, input int d, input logic c);
        resp_t r;
        r.none = 1'b0; r.corrupt = c; r.pid = p; r.dly = 8'(d);
        return r;
    endfunction

    function automatic resp_t nr();
        resp_t r;
        r.none = 1'b1; r.corrupt = 1'b0; r.pid = 8'h00; r.dly = 8'h00;
        return r;
    endfunction

    function automatic vec_t mkv(input logic dir, input logic clr, input logic [63:0] wd,
                                 input logic [63:0] pay, input resp_t a, input resp_t b,
                                 input resp_t c, input logic es, input logic est,
                                 input int ea, input logic gap);
        vec_t v;
        v.dir = dir; v.clr = clr; v.wdata = wd; v.pay = pay;
        v.r0 = a; v.r1 = b; v.r2 = c;
        v.esucc = es; v.estl = est; v.eatt = ea; v.chk_gap = gap;
        return v;
    endfunction

    function automatic resp_t pick(input vec_t v, input int a);
        if (a == 0) return v.r0;
        if (a == 1) return v.r1;
        return v.r2;
    endfunction

    // Device model and monitors, all sampling on the falling edge.
    initial begin
        int    cnt;
        int    inj_seen;
        resp_t cur;
        done_t e;
        cnt = 0;
        inj_seen = 0;
        cur = nr();
        dec_valid = 1'b0; dec_corrupt = 1'b0; dec_pid = '0; dec_payload = '0;
        forever begin
            @(negedge clk);
            dec_valid = 1'b0; dec_corrupt = 1'b0; dec_pid = '0; dec_payload = '0;
            if (!rst_b) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    dec_valid = 1'b1; dec_corrupt = cur.corrupt;
                    dec_pid = cur.pid; dec_payload = cur_pay;
                end
            end
            if (inj_cnt != inj_seen) begin
                inj_seen = inj_cnt;
                dec_valid = 1'b1; dec_pid = P_ACK;
            end
            if (rst_b && enc_valid && enc_ready) begin
                if (pid_q.size() == 0) chk("enc_pid_unexpected", {56'h0, enc_pid}, 64'hFF);
                else chk("enc_pid", {56'h0, enc_pid}, {56'h0, pid_q.pop_front()});
                if (enc_pid == P_OUT || enc_pid == P_IN)
                    chk("enc_token", {45'h0, enc_token}, {45'h0, cur_token});
                if (enc_pid == P_D0 || enc_pid == P_D1)
                    chk("enc_payload", enc_payload, cur_wdata);
                if (enc_pid == P_IN) tok_cyc.push_back(cyc);
                if (enc_pid == P_IN || enc_pid == P_D0 || enc_pid == P_D1) begin
                    if (resp_q.size() == 0) begin
                        chk("resp_underflow", 64'd0, 64'd1);
                    end else begin
                        cur = resp_q.pop_front();
                        if (!cur.none) cnt = int'(cur.dly);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e = done_q.pop_front();
                    chk("success", {63'h0, success}, {63'h0, e.succ});
                    chk("stalled", {63'h0, stalled}, {63'h0, e.stl});
                    chk("attempts", {56'h0, attempts}, {56'h0, e.att});
                    $display("xact %0d: success=%0b stalled=%0b attempts=%0d",
                             done_cnt, success, stalled, attempts);
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_valid_unexpected", 64'd1, 64'd0);
                else chk("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        resp_t r;
        done_t e;
        int    n0;
        cur_wdata = v.wdata;
        cur_pay   = v.pay;
        cur_token = 19'($urandom);
        if (v.clr) begin
            mdl_out = 1'b0;
            mdl_in  = 1'b0;
        end
        for (int a = 0; a < v.eatt; a++) begin
            r = pick(v, a);
            resp_q.push_back(r);
            if (!v.dir) begin
                pid_q.push_back(P_OUT);
                pid_q.push_back(mdl_out ? P_D1 : P_D0);
                if (!r.none && !r.corrupt && r.pid == P_ACK) mdl_out = ~mdl_out;
            end else begin
                pid_q.push_back(P_IN);
                if (!r.none && !r.corrupt && (r.pid == P_D0 || r.pid == P_D1)) begin
                    pid_q.push_back(P_ACK);
                    if ((r.pid == P_D1) == mdl_in) begin
                        mdl_in = ~mdl_in;
                        rd_q.push_back(v.pay);
                    end
                end
            end
        end
        e.succ = v.esucc; e.stl = v.estl; e.att = 8'(v.eatt);
        done_q.push_back(e);
        if (v.chk_gap) tok_cyc.delete();
        n0 = done_cnt;
        xact_dir = v.dir; wr_data = v.wdata; token_in = cur_token;
        toggle_clr = v.clr; xact_start = 1'b1;
        @(negedge clk);
        xact_start = 1'b0; toggle_clr = 1'b0;
        for (int k = 0; k < 2000 && done_cnt == n0; k++) @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'(n0 + 1));
        @(negedge clk);
        if (v.chk_gap) begin
            chk("tmo_tokens", 64'(tok_cyc.size()), 64'd3);
            if (tok_cyc.size() >= 3) begin
                chk("tmo_gap0", 64'(tok_cyc[1] - tok_cyc[0]), 64'(TL + 1));
                chk("tmo_gap1", 64'(tok_cyc[2] - tok_cyc[1]), 64'(TL + 1));
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        int   n0;
        rst_b = 1'b0; xact_start = 1'b0; xact_dir = 1'b0; toggle_clr = 1'b0;
        token_in = '0; wr_data = '0; enc_ready = 1'b1;

        tbl[0]  = mkv(0, 0, 64'h1111_2222_3333_4444, 0, rs(P_ACK, 5, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[1]  = mkv(0, 0, 64'hDEAD_BEEF_0000_0001, 0, rs(P_ACK, 2, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[2]  = mkv(0, 0, 64'h0F0F_0F0F_0F0F_0F0F, 0, rs(P_NAK, 4, 0), rs(P_NAK, 4, 0), rs(P_NAK, 4, 0), 0, 0, 3, 0);
        tbl[3]  = mkv(0, 0, 64'hAAAA_5555_AAAA_5555, 0, rs(P_ACK, 1, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[4]  = mkv(1, 0, 0, 64'hCAFE_F00D_1234_5678, rs(P_D1, 3, 0), rs(P_D0, 3, 0), nr(), 1, 0, 2, 0);
        tbl[5]  = mkv(1, 0, 0, 64'h0123_4567_89AB_CDEF, rs(P_D1, 2, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[6]  = mkv(1, 0, 0, 64'h5, rs(P_STALL, 4, 0), nr(), nr(), 0, 1, 1, 0);
        tbl[7]  = mkv(0, 0, 64'h7777, 0, rs(P_STALL, 3, 0), nr(), nr(), 0, 1, 1, 0);
        tbl[8]  = mkv(0, 0, 64'h8888, 0, rs(P_ACK, 2, 1), rs(P_ACK, 2, 0), nr(), 1, 0, 2, 0);
        tbl[9]  = mkv(1, 0, 0, 64'h9999_0000_9999_0000, rs(P_D0, 3, 1), rs(P_D0, 2, 0), nr(), 1, 0, 2, 0);
        tbl[10] = mkv(0, 0, 64'hA0A0, 0, rs(P_D0, 2, 0), rs(P_ACK, 2, 0), nr(), 1, 0, 2, 0);
        tbl[11] = mkv(1, 0, 0, 64'hBBBB_CCCC_DDDD_EEEE, rs(P_NAK, 2, 0), rs(P_D1, 2, 0), nr(), 1, 0, 2, 0);
        tbl[12] = mkv(1, 0, 0, 64'h1212_3434_5656_7878, rs(P_D0, 2, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[13] = mkv(1, 1, 0, 64'hFEDC_BA98_7654_3210, rs(P_D0, 2, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[14] = mkv(0, 1, 64'hC1C1_C1C1, 0, rs(P_ACK, 3, 0), nr(), nr(), 1, 0, 1, 0);
        tbl[15] = mkv(1, 0, 0, 64'h0, nr(), nr(), nr(), 0, 0, 3, 1);

        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_enc_valid", {63'h0, enc_valid}, 64'd0);
        chk("rst_enc_pid", {56'h0, enc_pid}, 64'd0);
        chk("rst_attempts", {56'h0, attempts}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(tbl[i]);

        // toggle_clr alone in IDLE: out toggle is 1 here, next OUT must use DATA0
        toggle_clr = 1'b1;
        @(negedge clk);
        toggle_clr = 1'b0;
        mdl_out = 1'b0; mdl_in = 1'b0;
        run_vec(mkv(0, 0, 64'h0C1E_A500, 0, rs(P_ACK, 2, 0), nr(), nr(), 1, 0, 1, 0));

        // dec_valid while idle must not start or finish anything
        n0 = done_cnt;
        inj_cnt++;
        repeat (5) @(negedge clk);
        chk("idle_dec_done", 64'(done_cnt), 64'(n0));
        chk("idle_dec_busy", {63'h0, busy}, 64'd0);

        // encoder back-pressure in TOKEN, then reset mid-transaction
        enc_ready = 1'b0;
        cur_token = 19'h5A5A5;
        xact_dir = 1'b0; wr_data = 64'h1234; token_in = cur_token; xact_start = 1'b1;
        @(negedge clk);
        xact_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_enc_valid", {63'h0, enc_valid}, 64'd1);
            chk("bp_enc_pid", {56'h0, enc_pid}, {56'h0, P_OUT});
            chk("bp_enc_token", {45'h0, enc_token}, {45'h0, cur_token});
            @(negedge clk);
        end
        n0 = done_cnt;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_busy", {63'h0, busy}, 64'd0);
        chk("mid_rst_enc_valid", {63'h0, enc_valid}, 64'd0);
        chk("mid_rst_enc_pid", {56'h0, enc_pid}, 64'd0);
        chk("mid_rst_enc_token", {45'h0, enc_token}, 64'd0);
        chk("mid_rst_attempts", {56'h0, attempts}, 64'd0);
        chk("mid_rst_rd_data", rd_data, 64'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt), 64'(n0));
        rst_b = 1'b1;
        enc_ready = 1'b1;
        mdl_out = 1'b0; mdl_in = 1'b0;
        @(negedge clk);
        run_vec(mkv(0, 0, 64'h00AF_7E25, 0, rs(P_ACK, 2, 0), nr(), nr(), 1, 0, 1, 0));

        chk("pid_q_left", 64'(pid_q.size()), 64'd0);
        chk("resp_q_left", 64'(resp_q.size()), 64'd0);
        chk("done_q_left", 64'(done_q.size()), 64'd0);
        chk("rd_q_left", 64'(rd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
